// File: rtl/factorial_ctrl.sv
// rtl/factorial_ctrl.sv - sequences N*(N-1)*...*2 through an external handshaked multiplier
module factorial_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     n,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic                 mul_op_start,
    output logic                 mul_op_clear,
    input  logic                 mul_op_done,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_MUL_CLR,
        S_DONE
    } state_e;

    localparam logic [2*WIDTH-1:0] ACC_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]     cnt_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     mcand_q;
    logic                 op_start_q;
    logic                 op_clear_q;
    logic                 overflow_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 in_mul;
    logic                 overflow_d;

    assign in_mul = (state_q == S_MUL_REQ) || (state_q == S_MUL_WAIT) || (state_q == S_MUL_CLR);

    // Upper-half bits only matter while further multiplies remain; the last one may use all 2*WIDTH bits.
    assign overflow_d = (|mul_result[2*WIDTH-1:WIDTH]) && (cnt_q > WIDTH'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= ACC_ONE;
            cnt_q      <= '0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            op_start_q <= 1'b0;
            op_clear_q <= 1'b1;
            overflow_q <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (clear) begin
            state_q    <= S_IDLE;
            op_start_q <= 1'b0;
            op_clear_q <= in_mul;
            overflow_q <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            op_clear_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        acc_q      <= ACC_ONE;
                        cnt_q      <= n;
                        overflow_q <= 1'b0;
                        result_q   <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cnt_q <= WIDTH'(1)) begin
                        result_q <= acc_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        mplier_q   <= cnt_q;
                        mcand_q    <= acc_q[WIDTH-1:0];
                        op_start_q <= 1'b1;
                        state_q    <= S_MUL_REQ;
                    end
                end
                S_MUL_REQ: begin
                    state_q <= S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    if (mul_op_done) begin
                        acc_q      <= mul_result;
                        op_start_q <= 1'b0;
                        op_clear_q <= 1'b1;
                        if (overflow_d) begin
                            overflow_q <= 1'b1;
                        end
                        state_q    <= S_MUL_CLR;
                    end
                end
                S_MUL_CLR: begin
                    cnt_q <= cnt_q - WIDTH'(1);
                    if (overflow_q) begin
                        result_q <= acc_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        state_q  <= S_CHECK;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_multiplier   = mplier_q;
    assign mul_multiplicand = mcand_q;
    assign mul_op_start     = op_start_q;
    assign mul_op_clear     = op_clear_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign overflow         = overflow_q;
    assign result           = result_q;

endmodule
